// File: rtl/key_conditioner.sv
// Push-button / slide-switch front end: two-flop sync, debounce, edge pulses
// and optional auto-repeat of press pulses, one independent channel per key.
module key_conditioner #(
  parameter int unsigned          NUM_KEYS        = 9,
  parameter int unsigned          DEBOUNCE_CYCLES = 500000,
  parameter int unsigned          REPEAT_DELAY    = 25000000,
  parameter int unsigned          REPEAT_PERIOD   = 5000000,
  parameter logic [NUM_KEYS-1:0]  REPEAT_MASK     = 9'b000001111,
  parameter int unsigned          CNT_WIDTH       = 25
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] raw_keys,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rpt_st_e;

  localparam logic [CNT_WIDTH-1:0] DebLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DlyLast = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PerLast = CNT_WIDTH'(REPEAT_PERIOD - 1);

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_keys;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic [CNT_WIDTH-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_WIDTH-1:0] rpt_cnt_q, rpt_cnt_d;
    rpt_st_e              rpt_st_q, rpt_st_d;
    logic                 level_q, level_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 acc_press, acc_release, rpt_tick;

    always_comb begin
      deb_cnt_d   = '0;
      level_d     = level_q;
      acc_press   = 1'b0;
      acc_release = 1'b0;
      if (sync2_q[i] != level_q) begin
        if (deb_cnt_q == DebLast) begin
          level_d     = sync2_q[i];
          acc_press   = sync2_q[i];
          acc_release = ~sync2_q[i];
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
    end

    always_comb begin
      rpt_st_d  = rpt_st_q;
      rpt_cnt_d = rpt_cnt_q;
      rpt_tick  = 1'b0;
      unique case (rpt_st_q)
        StIdle: begin
          if (acc_press && REPEAT_MASK[i]) begin
            rpt_st_d  = StDelay;
            rpt_cnt_d = '0;
          end
        end
        StDelay: begin
          if (rpt_cnt_q == DlyLast) begin
            rpt_tick  = 1'b1;
            rpt_cnt_d = '0;
            rpt_st_d  = StRepeat;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        StRepeat: begin
          if (rpt_cnt_q == PerLast) begin
            rpt_tick  = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        default: rpt_st_d = StIdle;
      endcase
      // The release pulse is always the last event of a keystroke.
      if (acc_release) begin
        rpt_st_d  = StIdle;
        rpt_cnt_d = '0;
        rpt_tick  = 1'b0;
      end
      press_d   = acc_press | rpt_tick;
      release_d = acc_release;
    end

    always_ff @(posedge sysclk) begin
      if (rst) begin
        deb_cnt_q <= '0;
        rpt_cnt_q <= '0;
        rpt_st_q  <= StIdle;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        deb_cnt_q <= deb_cnt_d;
        rpt_cnt_q <= rpt_cnt_d;
        rpt_st_q  <= rpt_st_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timings.
module tb_key_conditioner;

  localparam int unsigned NK = 9;

  logic          sysclk = 1'b0;
  logic          rst;
  logic [NK-1:0] raw_keys;
  logic [NK-1:0] key_level, key_press, key_release;

  int errors = 0;
  int checks = 0;

  key_conditioner #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5),
    .REPEAT_MASK    (9'h00F),
    .CNT_WIDTH      (8)
  ) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .raw_keys   (raw_keys),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask

  task automatic check_outs(input string t, input int e, input logic [NK-1:0] lvl,
                            input logic [NK-1:0] prs, input logic [NK-1:0] rel);
    check_eq($sformatf("%s_level@%0d", t, e), 32'(key_level), 32'(lvl));
    check_eq($sformatf("%s_press@%0d", t, e), 32'(key_press), 32'(prs));
    check_eq($sformatf("%s_release@%0d", t, e), 32'(key_release), 32'(rel));
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    raw_keys = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic bit rep4(input int e);
    return (e >= 16) && ((e - 16) % 5 == 0);
  endfunction

  initial begin
    // Edge numbering: inputs driven just after edge e are "at edge e";
    // outputs checked just after edge e show the values registered there.
    do_reset();
    check_outs("reset", 0, '0, '0, '0);

    // 1: masked key held, single press at 6.
    raw_keys = 9'h010;
    for (int e = 1; e <= 30; e++) begin
      tick();
      check_outs("t1", e, (e >= 6) ? 9'h010 : 9'h000, (e == 6) ? 9'h010 : 9'h000, 9'h000);
    end

    // 2: 3-cycle glitches never accepted.
    do_reset();
    raw_keys = 9'h020;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check_outs("t2", e, '0, '0, '0);
      raw_keys = ((e <= 2) || (e >= 6 && e <= 8)) ? 9'h020 : 9'h000;
    end

    // 3: repeating key, release at 34 ends repeats.
    do_reset();
    raw_keys = 9'h001;
    for (int e = 1; e <= 45; e++) begin
      tick();
      check_outs("t3", e, (e >= 6 && e < 34) ? 9'h001 : 9'h000,
                 (e == 6 || e == 16 || e == 21 || e == 26 || e == 31) ? 9'h001 : 9'h000,
                 (e == 34) ? 9'h001 : 9'h000);
      raw_keys = (e < 28) ? 9'h001 : 9'h000;
    end

    // 4: simultaneous press; only channel 1 repeats.
    do_reset();
    raw_keys = 9'h102;
    for (int e = 1; e <= 27; e++) begin
      tick();
      check_outs("t4", e, (e >= 6) ? 9'h102 : 9'h000,
                 ((e == 6) ? 9'h102 : 9'h000) | (rep4(e) ? 9'h002 : 9'h000), 9'h000);
    end

    // 5: reset while held (rst high at edges 11,12) -> fresh press at 18.
    do_reset();
    raw_keys = 9'h004;
    for (int e = 1; e <= 35; e++) begin
      tick();
      check_outs("t5", e, ((e >= 6 && e <= 10) || e >= 18) ? 9'h004 : 9'h000,
                 (e == 6 || e == 18 || e == 28 || e == 33) ? 9'h004 : 9'h000, 9'h000);
      rst = (e == 10 || e == 11);
    end

    // 6: short hold, release before the first repeat.
    do_reset();
    raw_keys = 9'h008;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check_outs("t6", e, (e >= 6 && e <= 10) ? 9'h008 : 9'h000,
                 (e == 6) ? 9'h008 : 9'h000, (e == 11) ? 9'h008 : 9'h000);
      raw_keys = (e < 5) ? 9'h008 : 9'h000;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
